// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions: mode encodings, Q-format limits and a real-to-Q helper.
package fixed_pkg;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;
  localparam logic SAT_WRAP    = 1'b0;
  localparam logic SAT_CLAMP   = 1'b1;

  localparam int unsigned FX_MAX_W = 64;

  typedef struct packed {
    logic rnd;
    logic sat;
  } fx_mode_t;

  // Largest positive two's complement value of the given width, zero-extended.
  function automatic logic [FX_MAX_W-1:0] fx_max(input int unsigned width);
    return (FX_MAX_W'(1) << (width - 1)) - FX_MAX_W'(1);
  endfunction

  // Most negative value of the given width, sign-extended.
  function automatic logic [FX_MAX_W-1:0] fx_min(input int unsigned width);
    return ~fx_max(width);
  endfunction

  function automatic logic [FX_MAX_W-1:0] to_fixed(input real r, input int unsigned frac);
    real scale;
    scale = 1.0;
    for (int unsigned i = 0; i < frac; i++) scale = scale * 2.0;
    return FX_MAX_W'($rtoi(r * scale));
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational rescale of a full-width signed product: optional round half up, shift, wrap or clamp.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 14
) (
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic               i_round,
  input  logic               i_sat,
  output logic [WIDTH-1:0]   o_result_c,
  output logic               o_overflow_c
);

  localparam int unsigned PW = 2*WIDTH + 1;
  // Half an output LSB; collapses to zero when there are no fraction bits.
  localparam logic [PW-1:0] BIAS = (PW'(1) << FRAC) >> 1;

  logic [PW-1:0]        w_sum;
  logic signed [PW-1:0] w_q;
  logic [WIDTH+1:0]     w_hi;

  always_comb begin
    w_sum        = {i_prod[2*WIDTH-1], i_prod} + ((i_round == RND_HALF_UP) ? BIAS : '0);
    w_q          = $signed(w_sum) >>> FRAC;
    w_hi         = w_q[PW-1:WIDTH-1];
    o_overflow_c = ~((&w_hi) | ~(|w_hi));
    o_result_c   = w_q[WIDTH-1:0];
    if ((i_sat == SAT_CLAMP) && o_overflow_c) begin
      o_result_c = w_q[PW-1] ? WIDTH'(fx_min(WIDTH)) : WIDTH'(fx_max(WIDTH));
    end
  end

endmodule

// File: rtl/fixed_mult_pipe.sv
// Pipelined signed fixed-point multiplier with elastic valid/ready stages.
module fixed_mult_pipe
  import fixed_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned FRAC   = 14,
  parameter int unsigned STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_round,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow
);

  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned PW   = 2*WIDTH;

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_vin;

  // A slot moves on when any later slot has a hole or the output is taken.
  for (genvar k = 0; k < STAGES; k++) begin : g_adv
    if (k == LAST) begin : g_tail
      assign w_adv[k] = out_ready;
    end else begin : g_body
      assign w_adv[k] = out_ready | ~(&r_v[LAST:k+1]);
    end
  end

  assign w_en      = ~r_v | w_adv;
  assign w_vin     = {r_v[LAST-1:0], in_valid};
  assign in_ready  = w_en[0];
  assign out_valid = r_v[LAST];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else begin
      r_v <= (w_en & w_vin) | (~w_en & r_v);
    end
  end

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  fx_mode_t         r_mode0;

  always_ff @(posedge clk) begin
    if (in_valid & w_en[0]) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_mode0 <= '{rnd: in_round, sat: in_sat};
    end
  end

  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod;

  assign w_a_ext = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_b_ext = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  logic [PW-1:0] w_last_prod;
  fx_mode_t      w_last_mode;

  if (STAGES > 2) begin : g_prod
    logic [PW-1:0] r_prod [1:STAGES-2];
    fx_mode_t      r_mode [1:STAGES-2];

    // Slot 1 holds the fresh product; deeper slots only delay it.
    always_ff @(posedge clk) begin
      if (w_en[1] & r_v[0]) begin
        r_prod[1] <= w_prod;
        r_mode[1] <= r_mode0;
      end
      for (int unsigned k = 2; k <= STAGES-2; k++) begin
        if (w_en[k] & r_v[k-1]) begin
          r_prod[k] <= r_prod[k-1];
          r_mode[k] <= r_mode[k-1];
        end
      end
    end

    assign w_last_prod = r_prod[STAGES-2];
    assign w_last_mode = r_mode[STAGES-2];
  end else begin : g_direct
    assign w_last_prod = w_prod;
    assign w_last_mode = r_mode0;
  end

  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  fixed_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_round_sat (
    .i_prod       (w_last_prod),
    .i_round      (w_last_mode.rnd),
    .i_sat        (w_last_mode.sat),
    .o_result_c   (w_res),
    .o_overflow_c (w_ovf)
  );

  logic [WIDTH-1:0] r_result;
  logic             r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (w_en[LAST] & r_v[LAST-1]) begin
      r_result <= w_res;
      r_ovf    <= w_ovf;
    end
  end

  assign out_result   = r_result;
  assign out_overflow = r_ovf;

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Directed bench for fixed_mult_pipe in Q18.14/3-stage and Q8.8/5-stage configurations.
module tb_fixed_mult_pipe;
  import fixed_pkg::*;

  logic clk;
  logic rst;

  logic        iv0, ir0, ov0, ordy0, rnd0, sat0, ovf0;
  logic [31:0] ia0, ib0, res0;
  logic        iv1, ir1, ov1, ordy1, rnd1, sat1, ovf1;
  logic [15:0] ia1, ib1, res1;

  int cur;
  int n_cmp;
  int n_err;

  fixed_mult_pipe #(.WIDTH(32), .FRAC(14), .STAGES(3)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_a(ia0), .in_b(ib0),
    .in_round(rnd0), .in_sat(sat0), .out_valid(ov0), .out_ready(ordy0),
    .out_result(res0), .out_overflow(ovf0)
  );

  fixed_mult_pipe #(.WIDTH(16), .FRAC(8), .STAGES(5)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_a(ia1), .in_b(ib1),
    .in_round(rnd1), .in_sat(sat1), .out_valid(ov1), .out_ready(ordy1),
    .out_result(res1), .out_overflow(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int cw(); return (cur != 0) ? 16 : 32; endfunction
  function automatic int cf(); return (cur != 0) ? 8 : 14; endfunction
  function automatic int cs(); return (cur != 0) ? 5 : 3; endfunction

  function automatic logic get_ir();  return (cur != 0) ? ir1 : ir0; endfunction
  function automatic logic get_ov();  return (cur != 0) ? ov1 : ov0; endfunction
  function automatic logic get_ovf(); return (cur != 0) ? ovf1 : ovf0; endfunction
  function automatic logic get_iv();  return (cur != 0) ? iv1 : iv0; endfunction
  function automatic logic get_ordy(); return (cur != 0) ? ordy1 : ordy0; endfunction
  function automatic logic [31:0] get_res();
    return (cur != 0) ? {16'h0, res1} : res0;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input logic s);
    if (cur != 0) begin
      iv1 = v; ia1 = a[15:0]; ib1 = b[15:0]; rnd1 = r; sat1 = s;
    end else begin
      iv0 = v; ia0 = a; ib0 = b; rnd0 = r; sat0 = s;
    end
  endtask

  task automatic set_ordy(input logic v);
    if (cur != 0) ordy1 = v;
    else ordy0 = v;
  endtask

  function automatic logic signed [127:0] sx(input logic [31:0] v, input int w);
    logic signed [127:0] t;
    t = 128'(v);
    if (w < 32) t = t & ((128'sd1 <<< w) - 128'sd1);
    if (v[w-1]) t = t - (128'sd1 <<< w);
    return t;
  endfunction

  // Reference: exact integer product, compare the rescaled value against the representable range.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic r, input logic s);
    int w, f;
    logic signed [127:0] p, q, mx, mn;
    logic ovf;
    logic [31:0] res;
    w = cw();
    f = cf();
    p = sx(a, w) * sx(b, w);
    if (r && f > 0) p = p + (128'sd1 <<< (f - 1));
    q = p >>> f;
    mx = (128'sd1 <<< (w - 1)) - 128'sd1;
    mn = -(128'sd1 <<< (w - 1));
    ovf = (q > mx) || (q < mn);
    if (s && ovf) q = (q > 0) ? mx : mn;
    res = q[31:0];
    if (w < 32) res = res & ((32'd1 << w) - 32'd1);
    return {ovf, res};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    if (cw() == 16) v = {{16{v[15]}}, v[15:0]};
    v = $signed(v) >>> $urandom_range(0, cw() - 1);
    return (cw() == 16) ? {16'h0, v[15:0]} : v;
  endfunction

  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic r, input logic s, input logic [31:0] er, input logic eo);
    int lat;
    set_ordy(1'b1);
    @(posedge clk); #1;
    set_in(1'b1, a, b, r, s);
    @(negedge clk);
    check_eq({tag, "_rdy"}, 64'(get_ir()), 64'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      if (lat == 0) set_in(1'b0, a, b, r, s);
      lat++;
      @(negedge clk);
    end while (!get_ov() && lat < 40);
    check_eq({tag, "_lat"}, 64'(lat), 64'(cs()));
    check_eq({tag, "_res"}, 64'(get_res()), 64'(er));
    check_eq({tag, "_ovf"}, 64'(get_ovf()), 64'(eo));
    @(posedge clk); #1;
  endtask

  task automatic run_directed();
    if (cur == 0) begin
      single("s1_mul",  32'(to_fixed(1.5, 14)), 32'h00008000, 0, 0, 32'h0000C000, 0);
      single("s1_neg",  32'hFFFFC000, 32'hFFFFC000, 0, 0, 32'h00004000, 0);
      single("s2_trp",  32'h00000001, 32'h00002000, 0, 0, 32'h00000000, 0);
      single("s2_rnp",  32'h00000001, 32'h00002000, 1, 0, 32'h00000001, 0);
      single("s2_trn",  32'hFFFFFFFF, 32'h00002000, 0, 0, 32'hFFFFFFFF, 0);
      single("s2_rnn",  32'hFFFFFFFF, 32'h00002000, 1, 0, 32'h00000000, 0);
      single("s3_wrap", 32'h7FFFFFFF, 32'h00008000, 0, 0, 32'hFFFFFFFE, 1);
      single("s3_satp", 32'h7FFFFFFF, 32'h00008000, 0, 1, 32'h7FFFFFFF, 1);
      single("s3_satn", 32'h80000000, 32'h00008000, 0, 1, 32'h80000000, 1);
      single("s3_minw", 32'h80000000, 32'hFFFFC000, 0, 0, 32'h80000000, 1);
      single("s3_mins", 32'h80000000, 32'hFFFFC000, 1, 1, 32'h7FFFFFFF, 1);
    end else begin
      single("s6_mul",  32'(to_fixed(1.5, 8)), 32'h0200, 0, 0, 32'h0300, 0);
      single("s6_neg",  32'hFF00, 32'hFF00, 0, 0, 32'h0100, 0);
      single("s6_trp",  32'h0001, 32'h0080, 0, 0, 32'h0000, 0);
      single("s6_rnp",  32'h0001, 32'h0080, 1, 0, 32'h0001, 0);
      single("s6_trn",  32'hFFFF, 32'h0080, 0, 0, 32'hFFFF, 0);
      single("s6_rnn",  32'hFFFF, 32'h0080, 1, 0, 32'h0000, 0);
      single("s6_wrap", 32'h7FFF, 32'h0200, 0, 0, 32'hFFFE, 1);
      single("s6_satp", 32'h7FFF, 32'h0200, 0, 1, 32'h7FFF, 1);
      single("s6_satn", 32'h8000, 32'h0200, 0, 1, 32'h8000, 1);
      single("s6_minw", 32'h8000, 32'hFF00, 0, 0, 32'h8000, 1);
      single("s6_mins", 32'h8000, 32'hFF00, 1, 1, 32'h7FFF, 1);
    end
  endtask

  task automatic run_stream();
    logic [32:0] expq[$];
    logic [32:0] e;
    logic [31:0] a, b, held_res;
    logic        r, s, held_ovf, held, need_new, drop_seen;
    int sent, got, c, extra;
    sent = 0; got = 0; c = 0;
    held = 1'b0; need_new = 1'b1; drop_seen = 1'b0;
    a = '0; b = '0; r = 1'b0; s = 1'b0; held_res = '0; held_ovf = 1'b0;
    while (got < 20 && c < 300) begin
      @(posedge clk); #1;
      set_ordy(!(c >= 5 && c <= 14));
      if (sent < 20) begin
        if (need_new) begin
          a = rnd_op(); b = rnd_op();
          r = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
        end
        set_in(1'b1, a, b, r, s);
      end else begin
        set_in(1'b0, a, b, r, s);
      end
      @(negedge clk);
      if (held) begin
        check_eq("s4_hold_res", 64'(get_res()), 64'(held_res));
        check_eq("s4_hold_ovf", 64'(get_ovf()), 64'(held_ovf));
      end
      if (!get_ir() && !drop_seen) begin
        drop_seen = 1'b1;
        check_eq("s4_full", 64'(sent - got), 64'(cs()));
      end
      need_new = 1'b0;
      if (get_iv() && get_ir()) begin
        expq.push_back(ref_mul(a, b, r, s));
        sent++;
        need_new = 1'b1;
      end
      if (get_ov() && get_ordy()) begin
        if (expq.size() == 0) begin
          check_eq("s4_spurious", 64'(get_ov()), 64'd0);
        end else begin
          e = expq.pop_front();
          check_eq("s4_res", 64'(get_res()), 64'(e[31:0]));
          check_eq("s4_ovf", 64'(get_ovf()), 64'(e[32]));
        end
        got++;
      end
      held = get_ov() && !get_ordy();
      held_res = get_res();
      held_ovf = get_ovf();
      c++;
    end
    check_eq("s4_count", 64'(got), 64'd20);
    check_eq("s4_drop", 64'(drop_seen), 64'd1);
    check_eq("s4_left", 64'(expq.size()), 64'd0);
    extra = 0;
    repeat (2 * cs() + 2) begin
      @(negedge clk);
      extra += int'(get_ov());
    end
    check_eq("s4_extra", 64'(extra), 64'd0);
  endtask

  task automatic run_reset();
    int stale;
    set_ordy(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      set_in(1'b1, 32'h00000300 + 32'(i), 32'h00000200, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("s5_ov",  64'(get_ov()),  64'd0);
    check_eq("s5_res", 64'(get_res()), 64'd0);
    check_eq("s5_ovf", 64'(get_ovf()), 64'd0);
    check_eq("s5_rdy", 64'(get_ir()),  64'd1);
    set_ordy(1'b1);
    stale = 0;
    repeat (2 * cs() + 4) begin
      @(negedge clk);
      stale += int'(get_ov());
    end
    check_eq("s5_stale", 64'(stale), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    iv0 = 0; ia0 = '0; ib0 = '0; rnd0 = 0; sat0 = 0; ordy0 = 1;
    iv1 = 0; ia1 = '0; ib1 = '0; rnd1 = 0; sat1 = 0; ordy1 = 1;
    cur = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      cur = d;
      check_eq("rst_ov",  64'(get_ov()),  64'd0);
      check_eq("rst_res", 64'(get_res()), 64'd0);
      check_eq("rst_ovf", 64'(get_ovf()), 64'd0);
      check_eq("rst_rdy", 64'(get_ir()),  64'd1);
    end
    for (int d = 0; d < 2; d++) begin
      cur = d;
      run_directed();
      run_stream();
      run_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
